// File: rtl/gnr_cycle_ctrl.sv
// Sweep sequencer for the gnr node array: loads each initial state, steps the
// slow/fast lanes Floyd-style and emits one attractor/timeout record per state.
module gnr_cycle_ctrl #(
    parameter int N_NODES = 8,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_base,
    input  logic [N_NODES:0]   num_inits,
    input  logic [STEP_W-1:0]  max_steps,
    input  logic [N_NODES-1:0] stat_s0,
    input  logic [N_NODES-1:0] stat_s1,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [STEP_W-1:0]  res_steps,
    output logic               res_timeout,
    output logic               busy,
    output logic               done
);
    typedef enum logic [2:0] {IDLE, LOAD, STEP, CHECK, EMIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [N_NODES-1:0]   cur_q, cur_d;
    logic [N_NODES:0]     idx_q, idx_d;
    logic [N_NODES:0]     num_q, num_d;
    logic [STEP_W-1:0]    max_q, max_d;
    logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
    logic                 reset_nos_q, reset_nos_d;
    logic [N_NODES-1:0]   init_state_q, init_state_d;
    logic                 strobe_q, strobe_d;
    logic                 res_valid_q, res_valid_d;
    logic [STEP_W-1:0]    res_steps_q, res_steps_d;
    logic                 res_timeout_q, res_timeout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 match;

    // Odd steps are skipped: after step 1 both lanes trivially hold f(x).
    assign match = ~step_cnt_q[0] && (step_cnt_q >= STEP_W'(2)) && (stat_s0 == stat_s1);

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        idx_d         = idx_q;
        num_d         = num_q;
        max_d         = max_q;
        step_cnt_d    = step_cnt_q;
        res_steps_d   = res_steps_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            IDLE: if (start) begin
                num_d   = num_inits;
                max_d   = max_steps;
                cur_d   = init_base;
                idx_d   = '0;
                state_d = (num_inits == '0) ? DONE : LOAD;
            end
            LOAD: begin
                step_cnt_d = '0;
                state_d    = STEP;
            end
            STEP: begin
                step_cnt_d = (step_cnt_q == {STEP_W{1'b1}}) ? step_cnt_q : step_cnt_q + STEP_W'(1);
                state_d    = CHECK;
            end
            CHECK: begin
                if (match) begin
                    res_timeout_d = 1'b0;
                    res_steps_d   = step_cnt_q;
                    state_d       = EMIT;
                end else if (step_cnt_q >= max_q) begin
                    res_timeout_d = 1'b1;
                    res_steps_d   = step_cnt_q;
                    state_d       = EMIT;
                end else begin
                    state_d = STEP;
                end
            end
            EMIT: if (res_ready) begin
                idx_d   = idx_q + (N_NODES+1)'(1);
                cur_d   = cur_q + N_NODES'(1);
                state_d = (idx_q + (N_NODES+1)'(1) == num_q) ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        reset_nos_d  = (state_d == LOAD);
        init_state_d = (state_d == LOAD) ? cur_d : '0;
        strobe_d     = (state_d == STEP);
        res_valid_d  = (state_d == EMIT);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            idx_q         <= '0;
            num_q         <= '0;
            max_q         <= '0;
            step_cnt_q    <= '0;
            reset_nos_q   <= 1'b0;
            init_state_q  <= '0;
            strobe_q      <= 1'b0;
            res_valid_q   <= 1'b0;
            res_steps_q   <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            idx_q         <= idx_d;
            num_q         <= num_d;
            max_q         <= max_d;
            step_cnt_q    <= step_cnt_d;
            reset_nos_q   <= reset_nos_d;
            init_state_q  <= init_state_d;
            strobe_q      <= strobe_d;
            res_valid_q   <= res_valid_d;
            res_steps_q   <= res_steps_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign reset_nos   = reset_nos_q;
    assign init_state  = init_state_q;
    assign start_s0    = strobe_q;
    assign start_s1    = strobe_q;
    assign res_valid   = res_valid_q;
    assign res_init    = cur_q;
    assign res_steps   = res_steps_q;
    assign res_timeout = res_timeout_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// Randomized bench for gnr_cycle_ctrl with a node-array model and a
// reference that derives each record directly from the map f.
module tb_gnr_cycle_ctrl;
    localparam int N  = 8;
    localparam int SW = 16;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [N-1:0]  init_base = '0;
    logic [N:0]    num_inits = '0;
    logic [SW-1:0] max_steps = '0;
    logic [N-1:0]  stat_s0 = '0, stat_s1 = '0;
    logic          res_ready = 1'b0;
    logic          reset_nos, start_s0, start_s1, res_valid, res_timeout, busy, done;
    logic [N-1:0]  init_state, res_init;
    logic [SW-1:0] res_steps;

    always #5 clk = ~clk;

    gnr_cycle_ctrl #(.N_NODES(N), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .init_base(init_base),
        .num_inits(num_inits), .max_steps(max_steps), .stat_s0(stat_s0),
        .stat_s1(stat_s1), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .res_valid(res_valid),
        .res_ready(res_ready), .res_init(res_init), .res_steps(res_steps),
        .res_timeout(res_timeout), .busy(busy), .done(done)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Node array: fast lane follows f every step, slow lane every other step
    // starting with the first one after a load.
    logic [N-1:0] fmap [256];
    logic         tog = 1'b0;
    always @(posedge clk) begin
        if (reset_nos) begin
            stat_s0 <= init_state;
            stat_s1 <= init_state;
            tog     <= 1'b1;
        end else begin
            if (start_s1) stat_s1 <= fmap[stat_s1];
            if (start_s0) begin
                if (tog) stat_s0 <= fmap[stat_s0];
                tog <= ~tog;
            end
        end
    end

    typedef struct packed {
        logic [N-1:0]  init;
        logic [SW-1:0] steps;
        logic          to;
    } rec_t;
    rec_t expq[$];

    // Tortoise b = f^(k/2)(x), hare a = f^k(x); compare only on even k >= 2.
    task automatic ref_run(input logic [N-1:0] x, input int mx, output rec_t r);
        logic [N-1:0] a, b;
        a = x; b = x;
        r.init = x;
        for (int k = 1; k < 65535; k++) begin
            a = fmap[a];
            if (k % 2 == 0) b = fmap[b];
            if (k % 2 == 0 && a == b) begin
                r.steps = SW'(k); r.to = 1'b0; return;
            end
            if (k >= mx) begin
                r.steps = SW'(k); r.to = 1'b1; return;
            end
        end
        r.steps = '1; r.to = 1'b1;
    endtask

    // Ready driver: random, forced low, or constant high.
    bit hold_low = 1'b0, rnd_ready = 1'b0;
    initial forever begin
        @(posedge clk); #1;
        res_ready = hold_low ? 1'b0 : (rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
    end

    // Monitor: strobe rules, load values, stall stability, record contents.
    int pulses = 0, done_cnt = 0;
    initial begin
        bit prev_stall;
        logic [N-1:0] p_init; logic [SW-1:0] p_steps; logic p_to;
        rec_t e;
        prev_stall = 0; p_init = '0; p_steps = '0; p_to = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                chk("strobe_excl", 32'(reset_nos & start_s0), 0);
                chk("strobe_pair", 32'(start_s0), 32'(start_s1));
                if (reset_nos) begin
                    pulses = 0;
                    if (expq.size() != 0) chk("load_value", 32'(init_state), 32'(expq[0].init));
                end else if (start_s0) pulses++;
                if (done) done_cnt++;
                if (prev_stall) begin
                    chk("hold_valid", 32'(res_valid), 1);
                    chk("hold_init", 32'(res_init), 32'(p_init));
                    chk("hold_steps", 32'(res_steps), 32'(p_steps));
                    chk("hold_to", 32'(res_timeout), 32'(p_to));
                end
                prev_stall = res_valid && !res_ready;
                p_init = res_init; p_steps = res_steps; p_to = res_timeout;
                if (res_valid && res_ready) begin
                    if (expq.size() == 0) chk("extra_record", 1, 0);
                    else begin
                        e = expq.pop_front();
                        chk("rec_init", 32'(res_init), 32'(e.init));
                        chk("rec_steps", 32'(res_steps), 32'(e.steps));
                        chk("rec_timeout", 32'(res_timeout), 32'(e.to));
                        chk("step_pulses", 32'(pulses), 32'(e.steps));
                    end
                end
            end
        end
    end

    task automatic start_sweep(input logic [N-1:0] base, input int num, input int mx);
        rec_t r;
        for (int i = 0; i < num; i++) begin
            ref_run(base + N'(i), mx, r);
            expq.push_back(r);
        end
        @(posedge clk); #1;
        init_base = base; num_inits = (N+1)'(num); max_steps = SW'(mx); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("lat_load", 32'(reset_nos), 32'(num > 0));
        chk("lat_busy", 32'(busy), 1);
        chk("lat_done0", 32'(done), 32'(num == 0));
        @(negedge clk);
        chk("lat_step", 32'(start_s0), 32'(num > 0));
    endtask

    task automatic wait_done(input int d0);
        bit seen;
        seen = 0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 1);
        @(negedge clk);
        chk("done_count", 32'(done_cnt - d0), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("queue_empty", 32'(expq.size()), 0);
        expq.delete();
    endtask

    task automatic map_ident(); for (int i = 0; i < 256; i++) fmap[i] = N'(i); endtask
    task automatic map_inc();   for (int i = 0; i < 256; i++) fmap[i] = N'(i + 1); endtask

    initial begin
        int d0;
        bit seen;
        #1;
        chk("rst_outputs", {reset_nos, init_state, start_s0, start_s1, res_valid,
                            res_timeout, busy, done, res_steps[7:0]}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // fixed point
        map_ident(); d0 = done_cnt;
        start_sweep(8'd5, 1, 10); wait_done(d0);

        // rho 0->1->2->3->1
        map_ident(); fmap[0] = 8'd1; fmap[1] = 8'd2; fmap[2] = 8'd3; fmap[3] = 8'd1;
        d0 = done_cnt; start_sweep(8'd0, 1, 20); wait_done(d0);

        // timeout with wrap of cur
        map_inc(); d0 = done_cnt;
        start_sweep(8'd255, 2, 7); wait_done(d0);

        // max_steps 0 and 1 time out at step 1
        d0 = done_cnt; start_sweep(8'd4, 1, 0); wait_done(d0);
        d0 = done_cnt; start_sweep(8'd9, 1, 1); wait_done(d0);

        // backpressure: 20 cycles of res_ready low in EMIT
        map_ident(); hold_low = 1'b1; d0 = done_cnt;
        start_sweep(8'd7, 1, 4);
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("bp_valid_seen", 32'(seen), 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_no_strobe", 32'(start_s0 | reset_nos), 0);
        end
        hold_low = 1'b0;
        @(negedge clk); chk("bp_still_valid", 32'(res_valid), 1);
        @(negedge clk); chk("bp_xfer_done", {31'd0, res_valid}, 0); chk("bp_done", 32'(done), 1);
        @(negedge clk); chk("bp_idle", 32'(busy), 0); chk("bp_queue", 32'(expq.size()), 0);
        expq.delete();

        // num_inits = 0
        d0 = done_cnt; start_sweep(8'd10, 0, 5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("zero_no_strobe", 32'(start_s0 | reset_nos | res_valid | busy), 0);
        end
        chk("zero_done_count", 32'(done_cnt - d0), 1);

        // start while busy is ignored
        map_inc(); rnd_ready = 1'b1; d0 = done_cnt;
        start_sweep(8'd20, 3, 9);
        repeat (5) @(posedge clk);
        #1; init_base = 8'd99; num_inits = '0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(d0);

        // asynchronous reset in the middle of CHECK
        rnd_ready = 1'b0;
        start_sweep(8'd3, 2, 20);
        @(posedge clk); #2; rst = 1'b1; #1;
        chk("arst_outputs", {reset_nos, init_state, start_s0, start_s1, res_valid,
                             res_timeout, busy, done, res_steps[7:0], res_init}, 0);
        expq.delete();
        #1; rst = 1'b0;
        d0 = done_cnt; start_sweep(8'd3, 2, 20); wait_done(d0);

        // random maps, configurations and ready patterns
        rnd_ready = 1'b1;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 256; i++) fmap[i] = N'($urandom_range(0, 255));
            d0 = done_cnt;
            start_sweep(N'($urandom_range(0, 255)), $urandom_range(1, 4), $urandom_range(0, 40));
            wait_done(d0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end
endmodule
